tod_calendar_conv: RTL and testbench

Converts a GPS-style time-of-day (week number, second of week) into IRIG-B calendar fields: two-digit BCD year, month, day, hour, minute, second, three-digit BCD day-of-year, and the 17-bit binary second-of-day (IRIG-B SBS field).

It is the parametrised successor of the fixed-base TOD-to-BCD converter:

- Epoch is configurable.
- Time zone has quarter-hour granularity and either sign.
- A single iterative FSM replaces the wide compare chains and divider IPs.
- It uses a start/busy/done handshake and flags out-of-range input.

It sits between the TOD receiver and the IRIG-B frame encoder.

---
 rtl/tod_calendar_conv.sv | 272 +++++++++++++++++++++++++++
 tb/tb_tod_calendar_conv.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tod_calendar_conv.sv
`timescale 1ns/1ps
// tod_calendar_conv: GPS week / second-of-week to IRIG-B BCD calendar fields and SBS.
// Optional macro TOD_CONV_SEC_COMP_EN: fields describe the second after the latched TOD.
module tod_calendar_conv #(
   parameter logic [15:0] BASE_WEEK = 16'd1930,
   parameter int          BASE_YEAR = 2017
) (
   input  logic        clk_125m,
   input  logic        rst_n,
   input  logic        din_vld,
   input  logic [15:0] tod_week,
   input  logic [23:0] tod_sec,
   input  logic [7:0]  leap,
   input  logic [6:0]  tz_qhr,
   output logic        busy,
   output logic        dout_vld,
   output logic        dout_err,
   output logic        ovr,
   output logic [7:0]  year_bcd,
   output logic [7:0]  month_bcd,
   output logic [7:0]  day_bcd,
   output logic [7:0]  hour_bcd,
   output logic [7:0]  min_bcd,
   output logic [7:0]  sec_bcd,
   output logic [11:0] doy_bcd,
   output logic [16:0] sbs
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADJ, S_DIVD, S_HOUR, S_MIN, S_YEAR, S_MON, S_BCD, S_DONE
   } state_t;

   localparam logic [19:0] SEC_WEEK    = 20'd604800;
   localparam logic [19:0] SEC_DAY     = 20'd86400;
   localparam logic [19:0] SEC_HOUR    = 20'd3600;
   localparam logic [19:0] SEC_MIN     = 20'd60;
   localparam logic [11:0] BASE_YEAR_L = 12'(BASE_YEAR);
   localparam logic [11:0] MAX_YEAR    = 12'd2099;
   localparam logic [11:0] YEAR_OFS    = 12'd2000;
`ifdef TOD_CONV_SEC_COMP_EN
   localparam logic signed [20:0] SEC_COMP = 21'sd1;
`else
   localparam logic signed [20:0] SEC_COMP = 21'sd0;
`endif

   function automatic logic [4:0] mon_len(input logic [3:0] idx, input logic leap_yr);
      case (idx)
         4'd1:                      mon_len = leap_yr ? 5'd29 : 5'd28;
         4'd3, 4'd5, 4'd8, 4'd10:   mon_len = 5'd30;
         default:                   mon_len = 5'd31;
      endcase
   endfunction

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
   function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic b);
      logic [11:0] t;
      t = bcd;
      for (int k = 0; k < 3; k++) begin
         if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
         else                     t[4*k +: 4] = t[4*k +: 4];
      end
      dd_step = {t[10:0], b};
   endfunction

   state_t      r_state, w_next;
   logic [15:0] r_week;
   logic [23:0] r_sec;
   logic [7:0]  r_leap;
   logic [6:0]  r_tz;
   logic        r_busy, r_err, r_dout_vld, r_dout_err, r_ovr;
   logic [19:0] r_s;
   logic [15:0] r_days;
   logic [4:0]  r_hour;
   logic [5:0]  r_min;
   logic [11:0] r_year;
   logic [8:0]  r_d, r_doy;
   logic [3:0]  r_mon;
   logic [16:0] r_sbs;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_bin [0:6];
   logic [7:0]  r_bcd2 [0:5];
   logic [11:0] r_bcd_doy;
   logic [7:0]  r_year_bcd, r_month_bcd, r_day_bcd, r_hour_bcd, r_min_bcd, r_sec_bcd;
   logic [11:0] r_doy_bcd;
   logic [16:0] r_sbs_out;

   logic signed [20:0] w_tz_ext, w_tz_sec, w_s_raw;
   logic signed [17:0] w_week_adj, w_week_diff;
   logic [19:0]        w_s_adj;
   logic [15:0]        w_days_init;
   logic               w_adj_err, w_leap_yr;
   logic [8:0]         w_year_len;
   logic [4:0]         w_mon_len;

   assign w_tz_ext = {{14{r_tz[6]}}, r_tz};
   assign w_tz_sec = w_tz_ext * 21'sd900;
   assign w_s_raw  = $signed({1'b0, r_sec[19:0]}) + SEC_COMP + w_tz_sec - $signed({13'd0, r_leap});

   // Single week wrap of the adjusted second-of-week.
   always_comb begin
      w_s_adj    = w_s_raw[19:0];
      w_week_adj = $signed({2'b00, r_week});
      if (w_s_raw < 21'sd0) begin
         w_s_adj    = 20'(w_s_raw + 21'sd604800);
         w_week_adj = $signed({2'b00, r_week}) - 18'sd1;
      end else if (w_s_raw >= 21'sd604800) begin
         w_s_adj    = 20'(w_s_raw - 21'sd604800);
         w_week_adj = $signed({2'b00, r_week}) + 18'sd1;
      end else begin
         w_s_adj    = w_s_raw[19:0];
         w_week_adj = $signed({2'b00, r_week});
      end
   end

   // Weeks beyond 8191 past the base are far past 2099 and would overflow the day count.
   assign w_week_diff = w_week_adj - $signed({2'b00, BASE_WEEK});
   assign w_adj_err   = (r_sec >= {4'd0, SEC_WEEK}) || w_week_diff[17] || (w_week_diff[16:13] != 4'd0);
   assign w_days_init = {3'd0, w_week_diff[12:0]} * 16'd7;
   assign w_leap_yr   = (r_year[1:0] == 2'b00);
   assign w_year_len  = w_leap_yr ? 9'd366 : 9'd365;
   assign w_mon_len   = mon_len(r_mon, w_leap_yr);

   // State register
   always_ff @(posedge clk_125m or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (din_vld) w_next = S_ADJ; else w_next = S_IDLE;
         S_ADJ:  if (w_adj_err) w_next = S_DONE; else w_next = S_DIVD;
         S_DIVD: if (r_s >= SEC_DAY) w_next = S_DIVD; else w_next = S_HOUR;
         S_HOUR: if (r_s >= SEC_HOUR) w_next = S_HOUR; else w_next = S_MIN;
         S_MIN:  if (r_s >= SEC_MIN) w_next = S_MIN; else w_next = S_YEAR;
         S_YEAR: begin
            if (r_year > MAX_YEAR)                   w_next = S_DONE;
            else if (r_days >= {7'd0, w_year_len})   w_next = S_YEAR;
            else                                     w_next = S_MON;
         end
         S_MON:  if (r_d >= {4'd0, w_mon_len}) w_next = S_MON; else w_next = S_BCD;
         S_BCD:  if (r_bit_cnt == 3'd7) w_next = S_DONE; else w_next = S_BCD;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: input latch, iterative subtraction, BCD conversion and output registers
   always_ff @(posedge clk_125m or negedge rst_n) begin
      if (!rst_n) begin
         r_week <= 16'd0;  r_sec <= 24'd0;  r_leap <= 8'd0;  r_tz <= 7'd0;
         r_busy <= 1'b0;   r_err <= 1'b0;   r_dout_vld <= 1'b0;  r_dout_err <= 1'b0;  r_ovr <= 1'b0;
         r_s <= 20'd0;     r_days <= 16'd0; r_hour <= 5'd0;  r_min <= 6'd0;
         r_year <= 12'd0;  r_d <= 9'd0;     r_doy <= 9'd0;   r_mon <= 4'd0;
         r_sbs <= 17'd0;   r_bit_cnt <= 3'd0;
         for (int k = 0; k < 7; k++) r_bin[k] <= 8'd0;
         for (int k = 0; k < 6; k++) r_bcd2[k] <= 8'd0;
         r_bcd_doy <= 12'd0;
         r_year_bcd <= 8'd0; r_month_bcd <= 8'd0; r_day_bcd <= 8'd0;
         r_hour_bcd <= 8'd0; r_min_bcd <= 8'd0;   r_sec_bcd <= 8'd0;
         r_doy_bcd <= 12'd0; r_sbs_out <= 17'd0;
      end else begin
         r_dout_vld <= 1'b0;
         r_ovr      <= din_vld && r_busy;
         case (r_state)
            S_IDLE: begin
               if (din_vld) begin
                  r_week <= tod_week;  r_sec <= tod_sec;
                  r_leap <= leap;      r_tz  <= tz_qhr;
                  r_busy <= 1'b1;      r_err <= 1'b0;
               end
            end
            S_ADJ: begin
               r_err  <= w_adj_err;
               r_s    <= w_s_adj;
               r_days <= w_days_init;
               r_year <= BASE_YEAR_L;
               r_hour <= 5'd0;
               r_min  <= 6'd0;
               r_mon  <= 4'd0;
            end
            S_DIVD: begin
               if (r_s >= SEC_DAY) begin
                  r_s    <= r_s - SEC_DAY;
                  r_days <= r_days + 16'd1;
               end else begin
                  r_sbs  <= r_s[16:0];
               end
            end
            S_HOUR: begin
               if (r_s >= SEC_HOUR) begin
                  r_s    <= r_s - SEC_HOUR;
                  r_hour <= r_hour + 5'd1;
               end
            end
            S_MIN: begin
               if (r_s >= SEC_MIN) begin
                  r_s   <= r_s - SEC_MIN;
                  r_min <= r_min + 6'd1;
               end
            end
            S_YEAR: begin
               if (r_year > MAX_YEAR) begin
                  r_err <= 1'b1;
               end else if (r_days >= {7'd0, w_year_len}) begin
                  r_days <= r_days - {7'd0, w_year_len};
                  r_year <= r_year + 12'd1;
               end else begin
                  r_d   <= r_days[8:0];
                  r_doy <= r_days[8:0] + 9'd1;
               end
            end
            S_MON: begin
               if (r_d >= {4'd0, w_mon_len}) begin
                  r_d   <= r_d - {4'd0, w_mon_len};
                  r_mon <= r_mon + 4'd1;
               end else begin
                  // Day-of-year MSB is preloaded so nine bits fit in eight shift steps.
                  r_bin[0]  <= 8'(r_year - YEAR_OFS);
                  r_bin[1]  <= {4'd0, r_mon + 4'd1};
                  r_bin[2]  <= {3'd0, r_d[4:0] + 5'd1};
                  r_bin[3]  <= {3'd0, r_hour};
                  r_bin[4]  <= {2'd0, r_min};
                  r_bin[5]  <= {2'd0, r_s[5:0]};
                  r_bin[6]  <= r_doy[7:0];
                  for (int k = 0; k < 6; k++) r_bcd2[k] <= 8'd0;
                  r_bcd_doy <= {11'd0, r_doy[8]};
                  r_bit_cnt <= 3'd0;
               end
            end
            S_BCD: begin
               for (int k = 0; k < 6; k++) r_bcd2[k] <= 8'(dd_step({4'd0, r_bcd2[k]}, r_bin[k][7]));
               r_bcd_doy <= dd_step(r_bcd_doy, r_bin[6][7]);
               for (int k = 0; k < 7; k++) r_bin[k] <= {r_bin[k][6:0], 1'b0};
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            S_DONE: begin
               r_busy     <= 1'b0;
               r_dout_vld <= 1'b1;
               r_dout_err <= r_err;
               if (!r_err) begin
                  r_year_bcd  <= r_bcd2[0];
                  r_month_bcd <= r_bcd2[1];
                  r_day_bcd   <= r_bcd2[2];
                  r_hour_bcd  <= r_bcd2[3];
                  r_min_bcd   <= r_bcd2[4];
                  r_sec_bcd   <= r_bcd2[5];
                  r_doy_bcd   <= r_bcd_doy;
                  r_sbs_out   <= r_sbs;
               end
            end
            default: r_busy <= 1'b0;
         endcase
      end
   end

   assign busy      = r_busy;
   assign dout_vld  = r_dout_vld;
   assign dout_err  = r_dout_err;
   assign ovr       = r_ovr;
   assign year_bcd  = r_year_bcd;
   assign month_bcd = r_month_bcd;
   assign day_bcd   = r_day_bcd;
   assign hour_bcd  = r_hour_bcd;
   assign min_bcd   = r_min_bcd;
   assign sec_bcd   = r_sec_bcd;
   assign doy_bcd   = r_doy_bcd;
   assign sbs       = r_sbs_out;

endmodule

// File: tb/tb_tod_calendar_conv.sv
`timescale 1ns/1ps
// Scoreboard bench for tod_calendar_conv: an arithmetic calendar model predicts every
// result and its latency; a monitor compares whenever dout_vld pulses.
module tb_tod_calendar_conv;
   localparam logic [15:0] BW = 16'd1930;
   localparam int          BY = 2017;
`ifdef TOD_CONV_SEC_COMP_EN
   localparam int C = 1;
`else
   localparam int C = 0;
`endif

   typedef struct packed {
      logic        err;
      logic [76:0] f;
      int          lat;
      int          c_issue;
   } exp_t;

   logic        clk = 1'b0, rst_n = 1'b0, din_vld = 1'b0;
   logic [15:0] tod_week = 16'd0;
   logic [23:0] tod_sec = 24'd0;
   logic [7:0]  leap = 8'd0;
   logic [6:0]  tz_qhr = 7'd0;
   logic        busy, dout_vld, dout_err, ovr;
   logic [7:0]  year_bcd, month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd;
   logic [11:0] doy_bcd;
   logic [16:0] sbs;

   exp_t        q[$];
   exp_t        mon_e;
   logic [76:0] last_good = '0;
   int          cyc = 0, n_checks = 0, n_pass = 0, ovr_cnt = 0;

   tod_calendar_conv #(.BASE_WEEK(BW), .BASE_YEAR(BY)) dut (
      .clk_125m(clk), .rst_n(rst_n), .din_vld(din_vld), .tod_week(tod_week),
      .tod_sec(tod_sec), .leap(leap), .tz_qhr(tz_qhr), .busy(busy),
      .dout_vld(dout_vld), .dout_err(dout_err), .ovr(ovr), .year_bcd(year_bcd),
      .month_bcd(month_bcd), .day_bcd(day_bcd), .hour_bcd(hour_bcd),
      .min_bcd(min_bcd), .sec_bcd(sec_bcd), .doy_bcd(doy_bcd), .sbs(sbs)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [11:0] bcd(input int v);
      bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Reference: absolute seconds since the epoch, then plain division and calendar walks.
   function automatic exp_t model(input int wk, input int sec, input int lp, input int tz);
      exp_t e;
      longint t;
      int days, sod, y, d, m, doy;
      int mlen[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      logic [11:0] yb, mb, db, hb, nb, sb, ob;
      e.err = 1'b0; e.f = last_good; e.lat = 0; e.c_issue = 0;
      t = longint'(wk - int'(BW)) * 604800 + sec + C + tz * 900 - lp;
      if (t < 0) begin e.err = 1'b1; return e; end
      days = int'(t / 86400);
      sod  = int'(t % 86400);
      y = BY; d = days;
      while (y <= 2099 && d >= ((y % 4 == 0) ? 366 : 365)) begin
         d -= (y % 4 == 0) ? 366 : 365;
         y++;
      end
      if (y > 2099) begin e.err = 1'b1; return e; end
      doy = d + 1;
      if (y % 4 == 0) mlen[1] = 29;
      m = 0;
      while (d >= mlen[m]) begin d -= mlen[m]; m++; end
      yb = bcd(y - 2000); mb = bcd(m + 1); db = bcd(d + 1);
      hb = bcd(sod / 3600); nb = bcd((sod / 60) % 60); sb = bcd(sod % 60); ob = bcd(doy);
      e.f = {yb[7:0], mb[7:0], db[7:0], hb[7:0], nb[7:0], sb[7:0], ob, 17'(sod)};
      e.lat = 2 + (days % 7 + 1) + (sod / 3600 + 1) + ((sod / 60) % 60 + 1) + (y - BY + 1) + (m + 1) + 8 + 1;
      return e;
   endfunction

   // Called at a negedge: present one din_vld cycle; optionally predict its result.
   task automatic drive(input int wk, input int sec, input int lp, input int tz, input bit push);
      exp_t e;
      tod_week = 16'(wk); tod_sec = 24'(sec); leap = 8'(lp); tz_qhr = 7'(tz);
      din_vld = 1'b1;
      if (push) begin
         e = model(wk, sec, lp, tz);
         e.c_issue = cyc + 1;
         q.push_back(e);
         if (!e.err) last_good = e.f;
      end
      @(negedge clk);
   endtask

   task automatic wait_idle();
      bit done_f = 1'b0;
      for (int i = 0; i < 400 && !done_f; i++) begin
         if (!busy) done_f = 1'b1;
         else @(negedge clk);
      end
      if (!done_f) check("idle_timeout", 1'b0, 128'd1, 128'd0);
   endtask

   task automatic run1(input int wk, input int sec, input int lp, input int tz);
      drive(wk, sec, lp, tz, 1'b1);
      din_vld = 1'b0;
      wait_idle();
   endtask

   // Monitor: pops and compares on every dout_vld pulse.
   always @(posedge clk) begin
      #1;
      if (ovr) ovr_cnt++;
      if (dout_vld) begin
         if (q.size() == 0) begin
            check("unexpected_dout_vld", 1'b0, 128'd1, 128'd0);
         end else begin
            mon_e = q.pop_front();
            check("dout_err", dout_err == mon_e.err, 128'(dout_err), 128'(mon_e.err));
            check("fields", {year_bcd, month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd, doy_bcd, sbs} == mon_e.f,
                  128'({year_bcd, month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd, doy_bcd, sbs}), 128'(mon_e.f));
            if (!mon_e.err)
               check("latency", (cyc - mon_e.c_issue + 1) == mon_e.lat,
                     128'(cyc - mon_e.c_issue + 1), 128'(mon_e.lat));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ovr0, ca, la;
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, dout_vld, dout_err, ovr, year_bcd, month_bcd, day_bcd, hour_bcd,
            min_bcd, sec_bcd, doy_bcd, sbs} == '0,
            128'({busy, dout_vld, dout_err, ovr, year_bcd, month_bcd, day_bcd, hour_bcd,
            min_bcd, sec_bcd, doy_bcd, sbs}), 128'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run1(1930, 86417, 18, 0);
      run1(2094, 561618, 18, 0);
      run1(1930, 604799, 0, 32);
      run1(1931, 0, 0, -22);
      run1(1930, 0, 0, -22);
      run1(1930, 0, 0, 0);
      run1(6278, 300000, 0, 0);

      // Overrun five cycles after the first start pulse.
      ovr0 = ovr_cnt;
      drive(2000, 123456, 18, 8, 1'b1);
      din_vld = 1'b0;
      repeat (4) @(negedge clk);
      drive(1950, 7, 0, 0, 1'b0);
      din_vld = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      check("ovr_midrun", (ovr_cnt - ovr0) == 1, 128'(ovr_cnt - ovr0), 128'd1);

      // Start coincident with DONE is dropped; the next cycle is accepted.
      ovr0 = ovr_cnt;
      drive(3000, 400000, 10, -4, 1'b1);
      din_vld = 1'b0;
      ca = q[q.size() - 1].c_issue;
      la = q[q.size() - 1].lat;
      while (cyc < ca + la - 2) @(negedge clk);
      drive(1940, 1000, 0, 0, 1'b0);
      drive(2500, 200000, 5, 40, 1'b1);
      din_vld = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      check("ovr_at_done", (ovr_cnt - ovr0) == 1, 128'(ovr_cnt - ovr0), 128'd1);

      for (int i = 0; i < 60; i++) begin
         run1(1928 + int'($urandom_range(0, 4600)), int'($urandom_range(0, 604799)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 104)) - 48);
      end

      // Reset during a conversion: outputs clear and no result appears.
      drive(2200, 500000, 18, 0, 1'b1);
      din_vld = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_midrun", {busy, dout_vld, dout_err, ovr, year_bcd, month_bcd, day_bcd, hour_bcd,
            min_bcd, sec_bcd, doy_bcd, sbs} == '0,
            128'({busy, dout_vld, dout_err, ovr, year_bcd, month_bcd, day_bcd, hour_bcd,
            min_bcd, sec_bcd, doy_bcd, sbs}), 128'd0);
      q.delete();
      last_good = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (250) @(negedge clk);
      run1(1900, 0, 0, 0);
      run1(1935, 43210, 18, -48);

      repeat (5) @(negedge clk);
      check("queue_drained", q.size() == 0, 128'(q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
